piso_tx: RTL
============

// Module: piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of the single-bit D-trigger capture path.
//  Accepts a WIDTH-bit word over a valid/ready load handshake and drives it out one bit per
//  rising edge of C, with a data-valid strobe and a last-bit marker.
//  The receiving side samples SOUT/SVALID with D-trigger based capture logic.
//  The line idles at IDLE_VAL, which is also the value forced by reset.
// PARAMETERS
//  WIDTH      8  word length in bits; legal range 2..32
//  IDLE_VAL   1  SOUT level while idle and while CLR is asserted
//  MSB_FIRST  1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// PORTS
//  C           in   1      clock; all state changes on posedge C
//  CLR         in   1      reset, asynchronous, active-high
//  DIN         in   WIDTH  parallel word to send; sampled only on an accepted load
//  LOAD_VALID  in   1      DIN holds a word to send
//  LOAD_READY  out  1      transmitter can accept a word this cycle
//  SOUT        out  1      serial data, registered
//  SVALID      out  1      SOUT carries a data bit this cycle, registered
//  LAST        out  1      SOUT carries the final bit of the word, registered
//  BUSY        out  1      a word is in flight (state SHIFT)
// BEHAVIOUR
//  Reset (CLR=1, acts immediately, no clock needed):
//   - state=IDLE, shift reg=0, bit counter=0.
//   - SOUT=IDLE_VAL, SVALID=0, LAST=0, BUSY=0.
//   - LOAD_READY=0 while CLR is high.
//   - Asserting CLR mid-word aborts it; the remaining bits are dropped and never resent.
//  States:
//   - IDLE: SOUT=IDLE_VAL, SVALID=0.
//   - SHIFT: SVALID=1, SOUT=current bit.
//  LOAD_READY (combinational) = !CLR && (IDLE || (SHIFT && cnt==0)).
//  Accept = LOAD_VALID && LOAD_READY at posedge C:
//   - the shift reg takes DIN, cnt=WIDTH-1, next state is SHIFT;
//   - SOUT, SVALID and LAST take the first bit's values on the same edge.
//  Latency: word accepted at edge k -> first bit on SOUT during cycle k+1;
//   bit i (0-based send order) appears in cycle k+1+i.
//  Each posedge in SHIFT with cnt>0: shift toward the output end, cnt-=1, next bit to SOUT.
//  LAST=1 exactly in the cycle cnt==0 (final bit), with SVALID=1.
//  Posedge in SHIFT with cnt==0:
//   - if accept: back-to-back, no idle gap; the new word's first bit follows the previous LAST;
//   - otherwise: go to IDLE, SOUT=IDLE_VAL, SVALID=0, LAST=0.
//  DIN and LOAD_VALID are ignored while LOAD_READY=0; no internal queue.
//  The counter is $clog2(WIDTH) bits wide and never wraps below 0.
//  BUSY = (state==SHIFT); it stays 1 across back-to-back words.
//  CLR and an accept in the same cycle: CLR wins and the word is not taken.
// TESTING
//  1. CLR=1, then release; IDLE_VAL=1 -> SOUT=1, SVALID=0, LAST=0, BUSY=0;
//     LOAD_READY=0 during CLR, 1 after.
//  2. WIDTH=8, MSB_FIRST=1, load DIN=8'hA5 at edge k
//     -> cycles k+1..k+8: SOUT=1,0,1,0,0,1,0,1; SVALID=1; LAST only in k+8;
//     then idle at SOUT=1.
//  3. MSB_FIRST=0, DIN=8'h01 -> SOUT=1,0,0,0,0,0,0,0; LOAD_READY=0 from k+1 to k+7,
//     1 in k+8.
//  4. Back-to-back: 8'hFF, then 8'h00 accepted in the LAST cycle
//     -> 16 contiguous SVALID cycles, SOUT=8x1 then 8x0; BUSY=1 throughout; two LAST pulses.
//  5. CLR pulsed (between edges) during bit 3 of 8'h3C
//     -> outputs reset immediately; no further SVALID until a new load; the old word is not resumed.
//  6. LOAD_VALID held high with DIN changing mid-word -> the in-flight word is unchanged;
//     the next word = DIN sampled in the LAST cycle.

Source files
------------

// File: rtl/piso_tx.sv
// ---------------------------------------------------------------------------
// piso_tx -- parallel-in / serial-out transmitter
//
// Accepts a WIDTH-bit word over a valid/ready load handshake and shifts it
// out one bit per rising edge of C. SVALID flags data bits, and LAST marks
// the final bit of each word. While idle, and while CLR is high, the line
// rests at IDLE_VAL.
//
// Parameters
//   WIDTH      word length in bits (2..32)
//   IDLE_VAL   SOUT level while idle / in reset
//   MSB_FIRST  1: bit WIDTH-1 is sent first, 0: bit 0 is sent first
//
// Ports
//   C           in   clock, all state changes on posedge
//   CLR         in   asynchronous active-high reset
//   DIN         in   parallel word, sampled only on an accepted load
//   LOAD_VALID  in   DIN holds a word to send
//   LOAD_READY  out  transmitter can take a word this cycle (combinational)
//   SOUT        out  serial data (registered)
//   SVALID      out  SOUT carries a data bit (registered)
//   LAST        out  SOUT carries the final bit of the word (registered)
//   BUSY        out  a word is in flight
// ---------------------------------------------------------------------------
module piso_tx #(
  parameter int   WIDTH     = 8,
  parameter logic IDLE_VAL  = 1'b1,
  parameter logic MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             LAST,
  output logic             BUSY
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             last_q, last_d;

  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] sr_shifted;

  // The bit currently on SOUT is always the one at the output end of sr_q.
  // A shift therefore moves the register one place toward that end, and the
  // bit now adjacent to it becomes the next SOUT value.
  assign first_bit  = MSB_FIRST ? DIN[WIDTH-1]  : DIN[0];
  assign next_bit   = MSB_FIRST ? sr_q[WIDTH-2] : sr_q[1];
  assign sr_shifted = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                                : {1'b0, sr_q[WIDTH-1:1]};

  // Ready while idle, or while the final bit of the current word is on the
  // line, so that a new word can follow with no gap. CLR blocks any accept.
  assign LOAD_READY = !CLR && ((state_q == ST_IDLE) ||
                               ((state_q == ST_SHIFT) && (cnt_q == '0)));
  assign accept     = LOAD_VALID && LOAD_READY;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    svalid_d = svalid_q;
    last_d   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SHIFT;
          sr_d     = DIN;
          cnt_d    = CNT_LOAD;
          sout_d   = first_bit;
          svalid_d = 1'b1;
          last_d   = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cnt_q != '0) begin
          sr_d     = sr_shifted;
          cnt_d    = cnt_q - CNT_ONE;
          sout_d   = next_bit;
          svalid_d = 1'b1;
          // The bit going out after this edge is the final one.
          last_d   = (cnt_q == CNT_ONE);
        end else if (accept) begin
          // Back-to-back word: its first bit directly follows LAST.
          state_d  = ST_SHIFT;
          sr_d     = DIN;
          cnt_d    = CNT_LOAD;
          sout_d   = first_bit;
          svalid_d = 1'b1;
          last_d   = 1'b0;
        end else begin
          state_d  = ST_IDLE;
          sout_d   = IDLE_VAL;
          svalid_d = 1'b0;
          last_d   = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        sout_d   = IDLE_VAL;
        svalid_d = 1'b0;
        last_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      sout_q   <= IDLE_VAL;
      svalid_q <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      svalid_q <= svalid_d;
      last_q   <= last_d;
    end
  end

  assign SOUT   = sout_q;
  assign SVALID = svalid_q;
  assign LAST   = last_q;
  assign BUSY   = (state_q == ST_SHIFT);

endmodule
